// File: rtl/lsu_byte_master_if.sv
// Bundle of the core request/response handshake and the byte-wide memory port
// used by lsu_byte_master; master is the sequencer side, slave the environment.
interface lsu_byte_master_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_size;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [7:0]            mem_wdata;
  logic [7:0]            mem_rdata;

  modport master (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    input  rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    output rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/lsu_byte_master.sv
// Load/store sequencer: splits one W/H/B access into byte beats on a byte-wide
// memory port and returns a zero/sign-extended result or an alignment error.
module lsu_byte_master #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  lsu_byte_master_if.master  bus,
  output logic               busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [2:0] SZ_W  = 3'b000;
  localparam logic [2:0] SZ_HU = 3'b001;
  localparam logic [2:0] SZ_H  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b011;
  localparam logic [2:0] SZ_B  = 3'b100;

  logic [1:0]            state_r;
  logic [1:0]            k_r;
  logic                  we_r;
  logic [2:0]            size_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [31:0]           wdata_r;
  logic [31:0]           lanes_r;
  logic [31:0]           rsp_rdata_r;
  logic                  rsp_err_r;
  logic [31:0]           lanes_s;

  // Illegal size codes and misaligned W/H addresses are rejected at acceptance.
  function automatic logic req_error(input logic [2:0] size, input logic [1:0] lsb);
    case (size)
      SZ_W:        req_error = (lsb != 2'b00);
      SZ_HU, SZ_H: req_error = lsb[0];
      SZ_BU, SZ_B: req_error = 1'b0;
      default:     req_error = 1'b1;
    endcase
  endfunction

  function automatic logic [1:0] last_beat(input logic [2:0] size);
    case (size)
      SZ_W:        last_beat = 2'd3;
      SZ_HU, SZ_H: last_beat = 2'd1;
      default:     last_beat = 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] size, input logic [31:0] lanes);
    case (size)
      SZ_W:    extend_load = lanes;
      SZ_HU:   extend_load = {16'h0000, lanes[15:0]};
      SZ_H:    extend_load = {{16{lanes[15]}}, lanes[15:0]};
      SZ_BU:   extend_load = {24'h000000, lanes[7:0]};
      SZ_B:    extend_load = {{24{lanes[7]}}, lanes[7:0]};
      default: extend_load = 32'h0000_0000;
    endcase
  endfunction

  // Captured lanes including the byte arriving this beat, so the final beat
  // can produce the extended result at the same edge it enters RESP.
  always_comb begin
    lanes_s = lanes_r;
    lanes_s[{k_r, 3'b000} +: 8] = bus.mem_rdata;
  end

  // Sequencer state, latched request and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      k_r         <= 2'd0;
      we_r        <= 1'b0;
      size_r      <= 3'b000;
      addr_r      <= '0;
      wdata_r     <= 32'h0000_0000;
      lanes_r     <= 32'h0000_0000;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            we_r    <= bus.req_we;
            size_r  <= bus.req_size;
            addr_r  <= bus.req_addr;
            wdata_r <= bus.req_wdata;
            k_r     <= 2'd0;
            lanes_r <= 32'h0000_0000;
            if (req_error(bus.req_size, bus.req_addr[1:0])) begin
              state_r     <= RESP;
              rsp_err_r   <= 1'b1;
              rsp_rdata_r <= 32'h0000_0000;
            end else begin
              state_r <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!we_r) begin
            lanes_r <= lanes_s;
          end
          if (k_r == last_beat(size_r)) begin
            state_r     <= RESP;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= we_r ? 32'h0000_0000 : extend_load(size_r, lanes_s);
          end else begin
            k_r <= k_r + 2'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_r     <= IDLE;
            k_r         <= 2'd0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
          end
        end
        default: begin
          state_r <= IDLE;
          k_r     <= 2'd0;
        end
      endcase
    end
  end

  // Memory port decoded purely from registered state, counter and latched request.
  always_comb begin
    if (state_r == ACCESS) begin
      bus.mem_addr  = addr_r + ADDR_WIDTH'(k_r);
      bus.mem_we    = we_r;
      if (we_r) begin
        bus.mem_wdata = wdata_r[{k_r, 3'b000} +: 8];
      end else begin
        bus.mem_wdata = 8'h00;
      end
    end else begin
      bus.mem_addr  = '0;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = 8'h00;
    end
  end

  assign bus.req_ready = (state_r == IDLE);
  assign bus.rsp_valid = (state_r == RESP);
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
  assign busy          = (state_r != IDLE);

endmodule

// File: doc/lsu_byte_master.md
# lsu_byte_master

Load/store sequencer between the core's data-access stage and a byte-wide data memory port. It accepts one load or store per request using the core's five-code access size. It moves the data one byte per cycle over the memory port and returns a zero- or sign-extended 32-bit result. Misaligned and illegal requests get an error response and are never forwarded.

## Interface
- ADDR_WIDTH, 32, byte-address width of request and memory port.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept (high only in IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_size  input  3  000 W, 001 HU, 010 H, 011 BU, 100 B; 101–111 illegal.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  32  store data, little-endian, low bytes used for H/B.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  misaligned or illegal request.
- mem_addr  output  ADDR_WIDTH  byte address of the current beat.
- mem_we  output  1  byte write strobe, sampled by memory on the rising clk edge.
- mem_wdata  output  8  byte to write.
- mem_rdata  input  8  combinational read data for mem_addr.
- busy  output  1  state != IDLE.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we, size, addr, wdata and set beat counter k=0.
- Beat count N by size: W=4, H/HU=2, B/BU=1.
- Error check at acceptance:
  - Illegal size: error.
  - W with addr[1:0]!=0: error.
  - H/HU with addr[0]!=0: error.
  - B/BU: any address is legal.
  - On error, go to RESP with rsp_err=1 and rsp_rdata=0. No ACCESS cycle and no mem_we.
- Store sizes:
  - HU stores as H, BU stores as B (unsigned-ness is irrelevant for stores).
- ACCESS:
  - Drive mem_addr = addr+k, truncated modulo 2^ADDR_WIDTH.
  - Stores: mem_we=1, mem_wdata=wdata[8k+:8].
  - Loads: mem_we=0; capture mem_rdata into byte lane k at the clock edge.
  - k increments each cycle. After beat k=N-1, go to RESP.
- Load result in RESP:
  - W: the 4 captured bytes.
  - HU: zero-extend 16 bits.
  - H: sign-extend from bit 15.
  - BU: zero-extend 8 bits.
  - B: sign-extend from bit 7.
  - rsp_err=0.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On rsp_ready, go to IDLE. The next request cannot be accepted in the same cycle.
- Outside ACCESS: mem_we=0, mem_addr=0, mem_wdata=0.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, k=0.
- Request accepted at edge t:
  - ACCESS occupies cycles t+1 … t+N.
  - rsp_valid goes high in cycle t+N+1.
  - Word load/store: response 5 cycles after acceptance. Byte: 2 cycles. Error: 1 cycle.
- Throughput: one request per N+2 cycles minimum (IDLE, N×ACCESS, RESP).
- mem_* outputs are decoded from registered state and counter: glitch-free within the cycle, change only after a clock edge.
- req_* inputs are ignored outside IDLE; the latched copy is used.
- Reset mid-ACCESS:
  - Next edge returns to IDLE and drops mem_we.
  - Store beats already completed remain in memory; there is no rollback.
  - No response is produced for the aborted request.
- Reset during RESP: the response is discarded.
- Address wrap: a byte access at address 2^ADDR_WIDTH−1 is legal. Aligned multi-byte accesses cannot wrap.

## Test plan
- Store W 0xDEADBEEF @0x10, then load W @0x10 → ACCESS beats write 0xEF,0xBE,0xAD,0xDE to 0x10–0x13; load returns rsp_rdata=0xDEADBEEF, err=0, rsp_valid in cycle t+5.
- With 0x80 at 0x20 and 0xF0 at 0x21: load B @0x21 → 0xFFFFFFF0; BU @0x21 → 0x000000F0; H @0x20 → 0xFFFFF080; HU @0x20 → 0x0000F080.
- Store H 0x12345678 @0x30 → only 0x30=0x78 and 0x31=0x56 written; 0x32 unchanged; exactly 2 mem_we cycles.
- Load W @0x13, H @0x21, size 110 → each gives rsp_err=1, rsp_rdata=0, rsp_valid at t+1, no mem_we and no ACCESS cycles.
- Hold rsp_ready=0 for 3 cycles after a load → rsp_valid and data stable and req_ready=0 throughout; IDLE follows the rsp_ready cycle.
- Assert reset after the 2nd beat of a store W → next cycle IDLE, mem_we=0, rsp_valid never rises; bytes 0 and 1 updated, bytes 2 and 3 unchanged.
